// File: rtl/cu_pkg.sv
// Shared parameters, data/address types and write-back FSM state encoding
// for the conv NPU compute unit.
package cu_pkg;
   localparam int PE_NUM      = 32;
   localparam int DATA_W      = 32;
   localparam int FRAM_ADDR_W = 16;
   localparam int IDX_W       = $clog2(PE_NUM);

   typedef logic signed [DATA_W-1:0] data_t;
   typedef logic [FRAM_ADDR_W-1:0]   fram_addr_t;
   typedef logic [1:0]               cu_state_e;

   localparam cu_state_e ST_IDLE = 2'd0;
   localparam cu_state_e ST_WB   = 2'd1;
   localparam cu_state_e ST_DONE = 2'd2;
endpackage

// File: rtl/cu_pe.sv
// One processing element: a wrapping signed accumulator with MAC, bias add,
// clear, and capture into a result buffer with optional ReLU.
module cu_pe
   import cu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_clear,
   input  logic              i_mac,
   input  logic              i_bias,
   input  logic              i_capture,
   input  logic              i_relu,
   input  logic [DATA_W-1:0] i_kernel,
   input  logic [DATA_W-1:0] i_feature,
   output logic [DATA_W-1:0] o_buf
);

   data_t r_acc;
   data_t r_buf;
   data_t w_prod;

   // Only the low DATA_W bits of the product are kept, so a same-width multiply is exact.
   assign w_prod = $signed(i_kernel) * $signed(i_feature);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
         r_buf <= '0;
      end else if (i_clear) begin
         r_acc <= '0;
      end else if (i_capture) begin
         r_buf <= (i_relu && r_acc[DATA_W-1]) ? '0 : r_acc;
         r_acc <= '0;
      end else if (i_mac) begin
         r_acc <= r_acc + w_prod;
      end else if (i_bias) begin
         r_acc <= r_acc + $signed(i_kernel);
      end
   end

   assign o_buf = r_buf;

endmodule

// File: rtl/cu.sv
// Compute unit: PE array, uop legality checks, capture mask and the
// write-back FSM that streams captured results to feature RAM.
module cu
   import cu_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [PE_NUM*DATA_W-1:0] kernel_data,
   input  logic [DATA_W-1:0]        feature_data,
   input  logic [DATA_W-1:0]        valid_pe_num,
   input  logic [PE_NUM-1:0]        in_valid,
   input  logic [PE_NUM-1:0]        out_en,
   input  logic [PE_NUM-1:0]        calc_bias,
   input  logic [PE_NUM-1:0]        calc_relu,
   input  logic                     flush,
   input  logic [FRAM_ADDR_W-1:0]   wb_baseaddr,
   input  logic [DATA_W-1:0]        wb_ch_offset,
   input  logic                     last_uop,
   output logic [DATA_W-1:0]        result_out,
   output logic [FRAM_ADDR_W-1:0]   wb_addr,
   output logic                     result_out_valid,
   output logic                     wb_busy,
   output logic                     illegal_uop,
   output logic                     compute_done
);

   cu_state_e         r_state;
   logic [PE_NUM-1:0] r_mask;
   logic              r_last;
   logic              r_illegal;

   logic              w_busy;
   logic              w_vpnBad;
   logic              w_illegal;
   logic [PE_NUM-1:0] w_active;
   logic [PE_NUM-1:0] w_ctrl;
   logic [PE_NUM-1:0] w_conflict;
   logic [PE_NUM-1:0] w_legal;
   logic [PE_NUM-1:0] w_mac;
   logic [PE_NUM-1:0] w_bias;
   logic [PE_NUM-1:0] w_cap;
   logic [PE_NUM-1:0] w_maskNext;
   logic [IDX_W-1:0]  w_idx;
   logic [DATA_W-1:0] w_stride;
   logic [DATA_W-1:0] w_buf [PE_NUM];

   assign w_busy     = (r_state == ST_WB);
   assign w_vpnBad   = (valid_pe_num == '0) || (valid_pe_num > DATA_W'(PE_NUM));
   assign w_ctrl     = in_valid | out_en | calc_bias | calc_relu;
   assign w_conflict = (in_valid & calc_bias) | ((in_valid | calc_bias) & out_en);

   // flush overrides everything, so it also masks every other per-PE enable.
   assign w_legal = w_active & ~w_conflict & {PE_NUM{!flush}};
   assign w_mac   = w_legal & in_valid;
   assign w_bias  = w_legal & calc_bias;
   assign w_cap   = w_legal & out_en & {PE_NUM{r_state == ST_IDLE}};

   assign w_illegal = !flush && ((|(w_conflict & w_active)) ||
                                 (w_busy && (|out_en)) ||
                                 (|(w_ctrl & ~w_active)));

   for (genvar gi = 0; gi < PE_NUM; gi++) begin : g_pe
      assign w_active[gi] = !w_vpnBad && (valid_pe_num > DATA_W'(gi));

      cu_pe u_pe (
         .clk       (clk),
         .rst_n     (rst_n),
         .i_clear   (flush),
         .i_mac     (w_mac[gi]),
         .i_bias    (w_bias[gi]),
         .i_capture (w_cap[gi]),
         .i_relu    (calc_relu[gi]),
         .i_kernel  (kernel_data[gi*DATA_W +: DATA_W]),
         .i_feature (feature_data),
         .o_buf     (w_buf[gi])
      );
   end

   always_comb begin
      w_idx = '0;
      for (int i = PE_NUM - 1; i >= 0; i--) begin
         if (r_mask[i]) w_idx = IDX_W'(i);
      end
   end

   assign w_maskNext = r_mask & ~(PE_NUM'(1) << w_idx);
   assign w_stride   = DATA_W'(w_idx) * wb_ch_offset;

   // Emission is combinational from the registered mask, so it appears the cycle after capture.
   assign result_out_valid = w_busy;
   assign wb_busy          = w_busy;
   assign compute_done     = (r_state == ST_DONE);
   assign illegal_uop      = r_illegal;
   assign result_out       = w_busy ? w_buf[w_idx] : '0;
   assign wb_addr          = w_busy ? FRAM_ADDR_W'(DATA_W'(wb_baseaddr) + w_stride) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_mask    <= '0;
         r_last    <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         r_illegal <= w_illegal;
         case (r_state)
            ST_IDLE: begin
               if (|w_cap) begin
                  r_state <= ST_WB;
                  r_mask  <= w_cap;
                  r_last  <= last_uop;
               end
            end
            ST_WB: begin
               r_mask <= w_maskNext;
               if (w_maskNext == '0) r_state <= r_last ? ST_DONE : ST_IDLE;
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cu.sv
// Directed self-checking bench for the compute unit: MAC/ReLU write-back,
// flush during write-back, bias with sparse masks, illegal uops and reset abort.
module tb_cu;
   import cu_pkg::*;

   localparam logic [31:0] MASK27 = 32'h07FF_FFFF;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic [31:0]              kern [PE_NUM];
   logic [PE_NUM*DATA_W-1:0] kernel_data;
   logic [DATA_W-1:0]        feature_data;
   logic [DATA_W-1:0]        valid_pe_num;
   logic [PE_NUM-1:0]        in_valid;
   logic [PE_NUM-1:0]        out_en;
   logic [PE_NUM-1:0]        calc_bias;
   logic [PE_NUM-1:0]        calc_relu;
   logic                     flush;
   logic [FRAM_ADDR_W-1:0]   wb_baseaddr;
   logic [DATA_W-1:0]        wb_ch_offset;
   logic                     last_uop;
   logic [DATA_W-1:0]        result_out;
   logic [FRAM_ADDR_W-1:0]   wb_addr;
   logic                     result_out_valid;
   logic                     wb_busy;
   logic                     illegal_uop;
   logic                     compute_done;

   int checks = 0;
   int errors = 0;
   int sawBad;
   int expData [4];

   always #5 clk = ~clk;

   always_comb begin
      kernel_data = '0;
      for (int i = 0; i < PE_NUM; i++) kernel_data[i*DATA_W +: DATA_W] = kern[i];
   end

   cu dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .kernel_data      (kernel_data),
      .feature_data     (feature_data),
      .valid_pe_num     (valid_pe_num),
      .in_valid         (in_valid),
      .out_en           (out_en),
      .calc_bias        (calc_bias),
      .calc_relu        (calc_relu),
      .flush            (flush),
      .wb_baseaddr      (wb_baseaddr),
      .wb_ch_offset     (wb_ch_offset),
      .last_uop         (last_uop),
      .result_out       (result_out),
      .wb_addr          (wb_addr),
      .result_out_valid (result_out_valid),
      .wb_busy          (wb_busy),
      .illegal_uop      (illegal_uop),
      .compute_done     (compute_done)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   task automatic checkFlag(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input int cycles);
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic clearCtrl();
      in_valid  = '0;
      out_en    = '0;
      calc_bias = '0;
      calc_relu = '0;
      flush     = 1'b0;
      last_uop  = 1'b0;
   endtask

   task automatic expectEmit(input string tag, input int data, input int addr);
      checkFlag({tag, ".valid"}, result_out_valid, 1'b1);
      checkFlag({tag, ".busy"}, wb_busy, 1'b1);
      checkOutput({tag, ".data"}, result_out, data);
      checkOutput({tag, ".addr"}, 32'(wb_addr), addr);
   endtask

   task automatic expectIdle(input string tag, input logic done);
      checkFlag({tag, ".valid"}, result_out_valid, 1'b0);
      checkFlag({tag, ".busy"}, wb_busy, 1'b0);
      checkFlag({tag, ".done"}, compute_done, done);
   endtask

   initial begin
      clearCtrl();
      for (int i = 0; i < PE_NUM; i++) kern[i] = '0;
      feature_data = '0;
      valid_pe_num = 32'd27;
      wb_baseaddr  = '0;
      wb_ch_offset = '0;
      rst_n        = 1'b0;
      applyStimulus(2);

      // Reset state
      expectIdle("reset", 1'b0);
      checkFlag("reset.illegal", illegal_uop, 1'b0);
      checkOutput("reset.data", result_out, 32'd0);
      checkOutput("reset.addr", 32'(wb_addr), 32'd0);
      rst_n = 1'b1;
      applyStimulus(1);

      // Test 1/2: ten MACs, capture with ReLU, flush mid-stream
      for (int i = 0; i < PE_NUM; i++) kern[i] = i;
      feature_data = 32'd1;
      in_valid     = MASK27;
      applyStimulus(10);
      clearCtrl();
      out_en       = MASK27;
      calc_relu    = MASK27;
      last_uop     = 1'b1;
      wb_ch_offset = 32'd100;
      applyStimulus(1);
      clearCtrl();
      for (int k = 0; k < 27; k++) begin
         expectEmit($sformatf("t1.pe%0d", k), 10 * k, 100 * k);
         checkFlag($sformatf("t1.illegal%0d", k), illegal_uop, 1'b0);
         clearCtrl();
         if (k == 3) in_valid = MASK27;
         if (k == 5) begin
            flush    = 1'b1;
            in_valid = MASK27;
            out_en   = MASK27;
         end
         applyStimulus(1);
      end
      expectIdle("t1.done", 1'b1);
      applyStimulus(1);
      expectIdle("t1.after", 1'b0);

      out_en = 32'h3;
      applyStimulus(1);
      clearCtrl();
      expectEmit("t2.pe0", 0, 0);
      applyStimulus(1);
      expectEmit("t2.pe1", 0, 100);
      applyStimulus(1);
      expectIdle("t2.end", 1'b0);

      // Test 3: ReLU on negative accumulators, only PE3 rectified
      for (int i = 0; i < PE_NUM; i++) kern[i] = -i;
      feature_data = 32'd3;
      in_valid     = 32'hF;
      applyStimulus(2);
      clearCtrl();
      out_en       = 32'hF;
      calc_relu    = 32'h8;
      last_uop     = 1'b1;
      wb_baseaddr  = 16'd1000;
      wb_ch_offset = 32'd4;
      applyStimulus(1);
      clearCtrl();
      expData = '{0, -6, -12, 0};
      for (int k = 0; k < 4; k++) begin
         expectEmit($sformatf("t3.pe%0d", k), expData[k], 1000 + 4 * k);
         applyStimulus(1);
      end
      expectIdle("t3.done", 1'b1);
      applyStimulus(1);

      // Test 4: MAC then bias, sparse capture mask 0b1010
      for (int i = 0; i < PE_NUM; i++) kern[i] = 32'd5;
      feature_data = 32'd4;
      in_valid     = 32'hA;
      applyStimulus(1);
      clearCtrl();
      calc_bias = 32'hA;
      applyStimulus(1);
      clearCtrl();
      out_en       = 32'hA;
      wb_baseaddr  = 16'd200;
      wb_ch_offset = 32'd8;
      applyStimulus(1);
      clearCtrl();
      expectEmit("t4.pe1", 25, 208);
      applyStimulus(1);
      expectEmit("t4.pe3", 25, 224);
      applyStimulus(1);
      expectIdle("t4.end", 1'b0);

      // Test 5: out_en while busy, then in_valid+calc_bias on one PE
      kern[0] = 32'd7;
      kern[1] = 32'd9;
      kern[2] = 32'd5;
      feature_data = 32'd1;
      in_valid     = 32'h3;
      applyStimulus(1);
      clearCtrl();
      out_en       = 32'h3;
      last_uop     = 1'b1;
      wb_baseaddr  = 16'd0;
      wb_ch_offset = 32'd1;
      applyStimulus(1);
      clearCtrl();
      expectEmit("t5.pe0", 7, 0);
      checkFlag("t5.noIllegal", illegal_uop, 1'b0);
      out_en = 32'h1;
      applyStimulus(1);
      clearCtrl();
      expectEmit("t5.pe1", 9, 1);
      checkFlag("t5.illegalBusy", illegal_uop, 1'b1);
      in_valid  = 32'h4;
      calc_bias = 32'h4;
      applyStimulus(1);
      clearCtrl();
      expectIdle("t5.done", 1'b1);
      checkFlag("t5.illegalMacBias", illegal_uop, 1'b1);
      applyStimulus(1);
      checkFlag("t5.illegalPulse", illegal_uop, 1'b0);
      expectIdle("t5.after", 1'b0);
      out_en = 32'h7;
      applyStimulus(1);
      clearCtrl();
      for (int k = 0; k < 3; k++) begin
         expectEmit($sformatf("t5.recap%0d", k), 0, k);
         applyStimulus(1);
      end
      expectIdle("t5.end", 1'b0);

      // Test 6: reset asserted in the middle of a write-back
      for (int i = 0; i < PE_NUM; i++) kern[i] = 32'd1;
      in_valid = 32'hF;
      applyStimulus(1);
      clearCtrl();
      out_en   = 32'hF;
      last_uop = 1'b1;
      applyStimulus(1);
      clearCtrl();
      expectEmit("t6.pe0", 1, 0);
      applyStimulus(1);
      expectEmit("t6.pe1", 1, 1);
      #2;
      rst_n = 1'b0;
      #1;
      expectIdle("t6.reset", 1'b0);
      checkOutput("t6.reset.data", result_out, 32'd0);
      checkOutput("t6.reset.addr", 32'(wb_addr), 32'd0);
      applyStimulus(1);
      rst_n  = 1'b1;
      sawBad = 0;
      for (int k = 0; k < 6; k++) begin
         applyStimulus(1);
         if (compute_done || result_out_valid) sawBad++;
      end
      checkOutput("t6.noDoneAfterReset", sawBad, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cu.md
Name: cu

Overview:
- Compute unit of the conv NPU: an array of PE_NUM signed multiply-accumulate processing elements.
- All PEs share one broadcast feature word; each PE has its own kernel word from BRAM.
- The uop decoder drives per-PE control masks: MAC, bias, ReLU, output, flush.
- Captured results are serialized, one per clock, to feature RAM at base + pe_index*channel_offset.

Parameters:
PE_NUM, 32, number of processing elements (`PE_NUM)
DATA_W, 32, signed data word width (`DATA_RANGE)
FRAM_ADDR_W, 16, feature-RAM address width (`FRAM_ADDR_RANGE)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
kernel_data  in  PE_NUM x DATA_W  signed kernel/bias word per PE
feature_data  in  DATA_W  signed feature word broadcast to all PEs
valid_pe_num  in  DATA_W  number of active PEs (1..PE_NUM)
in_valid  in  PE_NUM  per-PE MAC enable
out_en  in  PE_NUM  per-PE result capture mask
calc_bias  in  PE_NUM  per-PE bias add
calc_relu  in  PE_NUM  per-PE ReLU applied at capture
flush  in  1  clear all accumulators
wb_baseaddr  in  FRAM_ADDR_W  write-back base address
wb_ch_offset  in  DATA_W  address stride per PE index
last_uop  in  1  marks capture as final uop of the layer
result_out  out  DATA_W  signed write-back data
wb_addr  out  FRAM_ADDR_W  write-back address
result_out_valid  out  1  result_out/wb_addr valid this cycle
wb_busy  out  1  write-back in progress
illegal_uop  out  1  one-cycle error pulse
compute_done  out  1  one-cycle layer-done pulse

Behaviour:
- Reset:
  - All outputs are 0; accumulators, capture buffer, mask and write-back pointer are 0; FSM is IDLE.
- Accumulator:
  - Per PE, signed DATA_W, two's-complement wrap. Product is truncated to its DATA_W LSBs.
- Per-edge priority for PE i with i < valid_pe_num (evaluate in this order):
  1. flush=1: every accumulator is cleared and all other control fields that cycle are ignored. No illegal_uop.
  2. out_en[i]=1 with FSM IDLE: capture. buf[i] = (calc_relu[i] && acc[i]<0) ? 0 : acc[i], using the pre-edge acc. acc[i] is then cleared. Mask bit i is set.
  3. in_valid[i]: acc[i] += kernel_data[i]*feature_data.
  4. calc_bias[i]: acc[i] += kernel_data[i].
- Illegal uops (each pulses illegal_uop for 1 cycle and the offending fields are ignored; no pulse when flush=1):
  - in_valid[i] and calc_bias[i] both set.
  - in_valid[i] or calc_bias[i] set in the same cycle as out_en[i].
  - out_en nonzero while wb_busy.
  - Any control bit set at index >= valid_pe_num.
  - Any control bit set while valid_pe_num==0 or valid_pe_num>PE_NUM.
- Write-back FSM states: IDLE, WB, DONE.
  - IDLE->WB on a legal capture with at least one mask bit. last_uop is latched at capture.
  - WB: one captured PE per cycle, ascending index. Unset mask bits are skipped with no bubble.
    - Per emission: result_out=buf[i], wb_addr=wb_baseaddr+i*wb_ch_offset (truncated to FRAM_ADDR_W), result_out_valid=1.
    - The first emission is registered in the cycle after the capture edge.
    - wb_busy=1 for every WB cycle.
  - After the final emission: go to DONE if last_uop was latched, else IDLE.
  - DONE: compute_done=1 for one cycle, then IDLE.
  - flush does not abort write-back; captured data is already buffered.
  - wb_baseaddr and wb_ch_offset are sampled live during WB and must stay stable.
- Reset mid-write-back aborts immediately to the reset state.

Decomposition:
- Shared package (cu_pkg): DATA_W, PE_NUM, FRAM_ADDR_W, signed data typedef, FRAM address typedef, FSM state enum.
- Sub-module cu_pe:
  - Contains one accumulator with MAC/bias/clear/capture+ReLU.
  - Generated PE_NUM times.
  - The top holds the mask, priority encoder and write-back FSM.

Test Plan:
1. MAC+ReLU+write-back: kernel_data[i]=i, feature=1, valid_pe_num=27, 10 cycles in_valid=all-ones, then out_en=calc_relu=all-ones with last_uop=1.
   -> 27 consecutive results 0,10,...,260 at addresses 0,100,...,2600; wb_busy high 27 cycles; compute_done pulses once after.
2. Flush asserted with in_valid, out_en still high during the write-back of test 1.
   -> write-back completes unchanged; no illegal_uop; a later capture reads zeros.
3. ReLU on negatives: kernel_data[i]=-i, feature=3, 2 MACs; capture PEs 0..3, calc_relu only on PE 3.
   -> results 0,-6,-12,0.
4. Bias then sparse mask: 1 MAC (k=5, f=4), then calc_bias (k=5), capture mask 0b1010.
   -> two results of 25, at base+1*off and base+3*off, in back-to-back cycles.
5. out_en during wb_busy, and in_valid+calc_bias on the same PE.
   -> illegal_uop one-cycle pulse each; accumulators and write-back stream unaffected.
6. Reset asserted mid-write-back.
   -> all outputs 0 immediately; no compute_done.
